// File: rtl/sirv_plic_claim_seq_pkg.sv
// ----------------------------------------------------------------------------
// sirv_plic_claim_seq_pkg
// Shared constants for the hardware PLIC claim/complete sequencer:
//   - FSM state encoding (3-bit)
//   - default PLIC base address and hart-0 claim/complete register offset
//   - ICB command field widths
// ----------------------------------------------------------------------------
package sirv_plic_claim_seq_pkg;

    localparam int ICB_AW = 32;
    localparam int ICB_DW = 32;

    localparam logic [ICB_AW-1:0] PLIC_BASE_DFLT = 32'h0C00_0000;
    localparam logic [ICB_AW-1:0] CLAIM_OFS_DFLT = 32'h0020_0004;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CLM_CMD  = 3'd1;
    localparam logic [2:0] ST_CLM_RSP  = 3'd2;
    localparam logic [2:0] ST_DISPATCH = 3'd3;
    localparam logic [2:0] ST_CMP_CMD  = 3'd4;
    localparam logic [2:0] ST_CMP_RSP  = 3'd5;

endpackage

// File: rtl/sirv_plic_claim_cnt.sv
// ----------------------------------------------------------------------------
// sirv_plic_claim_cnt
// Free-running count of completed interrupts; wraps modulo 2^CNT_W.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   inc      : increment by one this cycle
//   cnt      : current count
// ----------------------------------------------------------------------------
module sirv_plic_claim_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sirv_plic_claim_seq.sv
// ----------------------------------------------------------------------------
// sirv_plic_claim_seq
// ICB initiator servicing the PLIC hart-0 context in hardware: on plic_irq_i
// it reads the claim register, hands the ID to a hardware handler, and after
// the handler is done writes the ID back to the complete register.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   enable_i           : sequencer enable, only looked at in IDLE
//   plic_irq_i         : PLIC interrupt request (level)
//   o_icb_cmd_*        : ICB command channel (valid/ready/addr/read/wdata)
//   o_icb_rsp_*        : ICB response channel (valid/ready/rdata/err)
//   hdl_req_o/hdl_id_o : handler request and claimed ID
//   hdl_done_i         : handler done (pulse or level), used only in DISPATCH
//   busy_o             : FSM not in IDLE
//   err_o              : one-cycle pulse the cycle after an error response
//   cnt_o              : completed-interrupt count
//
// Handshake: a transfer on either ICB channel happens in the cycle where
// valid and ready are both high at the rising clock edge. The initiator keeps
// valid and all command fields stable until that edge; it never drops valid
// without a handshake. rsp_ready is only raised in the response states, so
// command valid and response ready are never high together and at most one
// transaction is outstanding.
// ----------------------------------------------------------------------------
module sirv_plic_claim_seq
    import sirv_plic_claim_seq_pkg::*;
#(
    parameter logic [31:0] PLIC_BASE = PLIC_BASE_DFLT,
    parameter logic [31:0] CLAIM_OFS = CLAIM_OFS_DFLT,
    parameter int          ID_W      = 10,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              plic_irq_i,
    output logic              o_icb_cmd_valid,
    input  logic              o_icb_cmd_ready,
    output logic [ICB_AW-1:0] o_icb_cmd_addr,
    output logic              o_icb_cmd_read,
    output logic [ICB_DW-1:0] o_icb_cmd_wdata,
    input  logic              o_icb_rsp_valid,
    output logic              o_icb_rsp_ready,
    input  logic [ICB_DW-1:0] o_icb_rsp_rdata,
    input  logic              o_icb_rsp_err,
    output logic              hdl_req_o,
    output logic [ID_W-1:0]   hdl_id_o,
    input  logic              hdl_done_i,
    output logic              busy_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  cnt_o
);

    localparam logic [ICB_AW-1:0] CLAIM_ADDR = PLIC_BASE + CLAIM_OFS;

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic            cmd_hs;
    logic            rsp_hs;
    logic [ID_W-1:0] rsp_id;
    logic            claim_ok;
    logic            cnt_inc;
    logic            err_q;
    logic            unused_rdata_hi;

    assign cmd_hs   = o_icb_cmd_valid & o_icb_cmd_ready;
    assign rsp_hs   = o_icb_rsp_valid & o_icb_rsp_ready;
    assign rsp_id   = o_icb_rsp_rdata[ID_W-1:0];
    // A claim of ID 0 means nothing was pending; it is not completed.
    assign claim_ok = (state == ST_CLM_RSP) & rsp_hs & ~o_icb_rsp_err & (rsp_id != '0);
    assign cnt_inc  = (state == ST_CMP_RSP) & rsp_hs & ~o_icb_rsp_err;

    // Claim data above the ID field carries no meaning here.
    assign unused_rdata_hi = ^o_icb_rsp_rdata[ICB_DW-1:ID_W];

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable_i && plic_irq_i) begin
                    state_nxt = ST_CLM_CMD;
                end
            end
            ST_CLM_CMD: begin
                if (cmd_hs) begin
                    state_nxt = ST_CLM_RSP;
                end
            end
            ST_CLM_RSP: begin
                if (rsp_hs) begin
                    state_nxt = claim_ok ? ST_DISPATCH : ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                if (hdl_done_i) begin
                    state_nxt = ST_CMP_CMD;
                end
            end
            ST_CMP_CMD: begin
                if (cmd_hs) begin
                    state_nxt = ST_CMP_RSP;
                end
            end
            ST_CMP_RSP: begin
                if (rsp_hs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        o_icb_cmd_valid = 1'b0;
        o_icb_cmd_addr  = '0;
        o_icb_cmd_read  = 1'b0;
        o_icb_cmd_wdata = '0;
        o_icb_rsp_ready = 1'b0;
        hdl_req_o       = 1'b0;
        busy_o          = (state != ST_IDLE);
        case (state)
            ST_CLM_CMD: begin
                o_icb_cmd_valid = 1'b1;
                o_icb_cmd_addr  = CLAIM_ADDR;
                o_icb_cmd_read  = 1'b1;
            end
            ST_CLM_RSP: o_icb_rsp_ready = 1'b1;
            ST_DISPATCH: hdl_req_o = 1'b1;
            ST_CMP_CMD: begin
                o_icb_cmd_valid = 1'b1;
                o_icb_cmd_addr  = CLAIM_ADDR;
                o_icb_cmd_wdata = {{(ICB_DW-ID_W){1'b0}}, hdl_id_o};
            end
            ST_CMP_RSP: o_icb_rsp_ready = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdl_id_o <= '0;
            err_q    <= 1'b0;
        end else begin
            if (claim_ok) begin
                hdl_id_o <= rsp_id;
            end
            err_q <= rsp_hs & o_icb_rsp_err;
        end
    end

    assign err_o = err_q;

    sirv_plic_claim_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (cnt_inc),
        .cnt (cnt_o)
    );

endmodule

// File: tb/tb_sirv_plic_claim_seq.sv
// ----------------------------------------------------------------------------
// tb_sirv_plic_claim_seq
// Directed bench for the PLIC claim/complete sequencer. The bench plays the
// ICB slave (PLIC) and the hardware handler, and keeps the claimed IDs in an
// expected queue that the completion write is checked against.
// ----------------------------------------------------------------------------
module tb_sirv_plic_claim_seq;

    localparam int          ID_W  = 10;
    localparam int          CNT_W = 16;
    localparam logic [31:0] ADDR  = 32'h0C20_0004;

    logic              clk;
    logic              rst;
    logic              enable_i;
    logic              plic_irq_i;
    logic              o_icb_cmd_valid;
    logic              o_icb_cmd_ready;
    logic [31:0]       o_icb_cmd_addr;
    logic              o_icb_cmd_read;
    logic [31:0]       o_icb_cmd_wdata;
    logic              o_icb_rsp_valid;
    logic              o_icb_rsp_ready;
    logic [31:0]       o_icb_rsp_rdata;
    logic              o_icb_rsp_err;
    logic              hdl_req_o;
    logic [ID_W-1:0]   hdl_id_o;
    logic              hdl_done_i;
    logic              busy_o;
    logic              err_o;
    logic [CNT_W-1:0]  cnt_o;

    int          total;
    int          bad;
    int          hs_cnt;
    int          overlap;
    int          hs_mark;
    logic [31:0] exp_q[$];

    sirv_plic_claim_seq dut (
        .clk             (clk),
        .rst             (rst),
        .enable_i        (enable_i),
        .plic_irq_i      (plic_irq_i),
        .o_icb_cmd_valid (o_icb_cmd_valid),
        .o_icb_cmd_ready (o_icb_cmd_ready),
        .o_icb_cmd_addr  (o_icb_cmd_addr),
        .o_icb_cmd_read  (o_icb_cmd_read),
        .o_icb_cmd_wdata (o_icb_cmd_wdata),
        .o_icb_rsp_valid (o_icb_rsp_valid),
        .o_icb_rsp_ready (o_icb_rsp_ready),
        .o_icb_rsp_rdata (o_icb_rsp_rdata),
        .o_icb_rsp_err   (o_icb_rsp_err),
        .hdl_req_o       (hdl_req_o),
        .hdl_id_o        (hdl_id_o),
        .hdl_done_i      (hdl_done_i),
        .busy_o          (busy_o),
        .err_o           (err_o),
        .cnt_o           (cnt_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitors: command handshakes and cmd_valid/rsp_ready overlap.
    always @(posedge clk) begin
        if (!rst && o_icb_cmd_valid && o_icb_cmd_ready) hs_cnt++;
        if (!rst && o_icb_cmd_valid && o_icb_rsp_ready) overlap++;
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd(output bit ok);
        int n;
        n = 0;
        while (!o_icb_cmd_valid && n < 20) begin
            tick();
            n++;
        end
        ok = o_icb_cmd_valid;
        if (!ok) chk("cmd_timeout", 32'd0, 32'd1);
    endtask

    // Accept one command after 'stall' not-ready cycles, checking the fields
    // stay put, then return one response.
    task automatic slave_xfer(input string tag, input bit exp_read, input logic [31:0] exp_wdata,
                              input int stall, input logic [31:0] rdata, input bit err,
                              input bit drop_irq);
        bit ok;
        wait_cmd(ok);
        if (!ok) return;
        if (drop_irq) plic_irq_i = 1'b0;
        chk({tag, "_read"}, {31'd0, o_icb_cmd_read}, {31'd0, exp_read});
        chk({tag, "_addr"}, o_icb_cmd_addr, ADDR);
        chk({tag, "_wdata"}, o_icb_cmd_wdata, exp_wdata);
        for (int i = 0; i < stall; i++) begin
            o_icb_cmd_ready = 1'b0;
            tick();
            chk({tag, "_stall_valid"}, {31'd0, o_icb_cmd_valid}, 32'd1);
            chk({tag, "_stall_addr"}, o_icb_cmd_addr, ADDR);
            chk({tag, "_stall_wdata"}, o_icb_cmd_wdata, exp_wdata);
        end
        o_icb_cmd_ready = 1'b1;
        tick();
        o_icb_cmd_ready = 1'b0;
        chk({tag, "_post_hs_valid"}, {31'd0, o_icb_cmd_valid}, 32'd0);
        chk({tag, "_rsp_ready"}, {31'd0, o_icb_rsp_ready}, 32'd1);
        o_icb_rsp_valid = 1'b1;
        o_icb_rsp_rdata = rdata;
        o_icb_rsp_err   = err;
        tick();
        o_icb_rsp_valid = 1'b0;
        o_icb_rsp_rdata = '0;
        o_icb_rsp_err   = 1'b0;
    endtask

    task automatic do_claim(input logic [31:0] rdata, input bit err, input int stall,
                            input bit drop_irq);
        slave_xfer("claim", 1'b1, 32'd0, stall, rdata, err, drop_irq);
        if (!err && rdata[ID_W-1:0] != '0) exp_q.push_back({22'd0, rdata[ID_W-1:0]});
    endtask

    task automatic do_complete(input int stall, input int done_dly, input bit err);
        logic [31:0] exp_id;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        exp_id = exp_q.pop_front();
        chk("dispatch_req", {31'd0, hdl_req_o}, 32'd1);
        chk("dispatch_id", {22'd0, hdl_id_o}, exp_id);
        for (int i = 0; i < done_dly; i++) tick();
        chk("dispatch_hold", {31'd0, hdl_req_o}, 32'd1);
        hdl_done_i = 1'b1;
        tick();
        hdl_done_i = 1'b0;
        chk("req_drop", {31'd0, hdl_req_o}, 32'd0);
        slave_xfer("cmp", 1'b0, exp_id, stall, 32'd0, err, 1'b0);
        chk("cmp_err_o", {31'd0, err_o}, {31'd0, err});
        chk("cmp_idle", {31'd0, busy_o}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total = 0; bad = 0; hs_cnt = 0; overlap = 0;
        rst = 1'b1; enable_i = 1'b0; plic_irq_i = 1'b0;
        o_icb_cmd_ready = 1'b0; o_icb_rsp_valid = 1'b0;
        o_icb_rsp_rdata = '0; o_icb_rsp_err = 1'b0; hdl_done_i = 1'b0;
        repeat (3) tick();
        chk("rst_cmd_valid", {31'd0, o_icb_cmd_valid}, 32'd0);
        chk("rst_rsp_ready", {31'd0, o_icb_rsp_ready}, 32'd0);
        chk("rst_hdl_req", {31'd0, hdl_req_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_cnt", {16'd0, cnt_o}, 32'd0);
        chk("rst_id", {22'd0, hdl_id_o}, 32'd0);
        rst = 1'b0;
        tick();

        // Disabled: irq alone does nothing; stray done is ignored.
        plic_irq_i = 1'b1;
        hdl_done_i = 1'b1;
        repeat (4) tick();
        hdl_done_i = 1'b0;
        chk("disabled_busy", {31'd0, busy_o}, 32'd0);
        chk("disabled_no_cmd", hs_cnt, 32'd0);

        // 1: basic claim of ID 5, registered start.
        enable_i = 1'b1;
        chk("start_not_yet", {31'd0, o_icb_cmd_valid}, 32'd0);
        tick();
        chk("start_valid", {31'd0, o_icb_cmd_valid}, 32'd1);
        do_claim(32'd5, 1'b0, 0, 1'b1);
        do_complete(0, 3, 1'b0);
        chk("t1_cnt", {16'd0, cnt_o}, 32'd1);

        // 2: spurious claim (ID 0) -> no write.
        hs_mark = hs_cnt;
        plic_irq_i = 1'b1;
        do_claim(32'd0, 1'b0, 0, 1'b1);
        chk("t2_idle", {31'd0, busy_o}, 32'd0);
        repeat (5) tick();
        chk("t2_no_write", hs_cnt - hs_mark, 32'd1);
        chk("t2_cnt", {16'd0, cnt_o}, 32'd1);

        // 3: 4-cycle stalls on both commands; upper rdata bits ignored.
        hs_mark = hs_cnt;
        plic_irq_i = 1'b1;
        do_claim(32'hFFFF_F2A5, 1'b0, 4, 1'b1);
        do_complete(4, 1, 1'b0);
        chk("t3_hs", hs_cnt - hs_mark, 32'd2);
        chk("t3_cnt", {16'd0, cnt_o}, 32'd2);

        // 4: claim error -> err_o pulse, no dispatch.
        hs_mark = hs_cnt;
        plic_irq_i = 1'b1;
        do_claim(32'd6, 1'b1, 0, 1'b1);
        chk("t4_err_pulse", {31'd0, err_o}, 32'd1);
        chk("t4_no_dispatch", {31'd0, hdl_req_o}, 32'd0);
        tick();
        chk("t4_err_clear", {31'd0, err_o}, 32'd0);
        repeat (3) tick();
        chk("t4_no_write", hs_cnt - hs_mark, 32'd1);
        // next irq serviced normally; disable mid-sequence has no effect
        plic_irq_i = 1'b1;
        do_claim(32'd1, 1'b0, 1, 1'b0);
        enable_i = 1'b0;
        do_complete(0, 0, 1'b0);
        chk("t4_cnt", {16'd0, cnt_o}, 32'd3);
        repeat (4) tick();
        chk("t4_disabled_idle", {31'd0, busy_o}, 32'd0);
        enable_i = 1'b1;

        // 5: irq held high through IDs 3 and 7, one IDLE cycle between.
        do_claim(32'd3, 1'b0, 0, 1'b0);
        do_complete(0, 2, 1'b0);
        tick();
        chk("t5_rearm", {31'd0, o_icb_cmd_valid}, 32'd1);
        do_claim(32'd7, 1'b0, 0, 1'b1);
        do_complete(0, 0, 1'b0);
        chk("t5_cnt", {16'd0, cnt_o}, 32'd5);

        // 6: async reset during DISPATCH.
        plic_irq_i = 1'b1;
        do_claim(32'd9, 1'b0, 0, 1'b1);
        chk("t6_dispatch", {31'd0, hdl_req_o}, 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_req", {31'd0, hdl_req_o}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("t6_rst_id", {22'd0, hdl_id_o}, 32'd0);
        chk("t6_rst_cnt", {16'd0, cnt_o}, 32'd0);
        chk("t6_rst_valid", {31'd0, o_icb_cmd_valid}, 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        plic_irq_i = 1'b1;
        tick();
        chk("t6_restart", {31'd0, o_icb_cmd_valid}, 32'd1);
        do_claim(32'd4, 1'b0, 0, 1'b1);
        do_complete(0, 1, 1'b1);
        chk("t6_cmp_err_cnt", {16'd0, cnt_o}, 32'd0);
        tick();
        chk("t6_err_clear", {31'd0, err_o}, 32'd0);

        chk("no_overlap", overlap, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
